// File: rtl/isa_types.sv
// Shared ISA-level types for the hart and its memory responder: access widths,
// captured request record, responder FSM states and alignment helper.
package isa_types;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    WidthByte = 2'd0,
    WidthHalf = 2'd1,
    WidthWord = 2'd2
  } write_width_t;

  typedef struct packed {
    logic            write;
    logic [XLEN-1:0] addr;
    write_width_t    width;
    logic            is_unsigned;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } resp_state_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lo, input write_width_t width);
    case (width)
      WidthHalf: is_misaligned = addr_lo[0];
      WidthWord: is_misaligned = |addr_lo;
      default:   is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// Load/store request/response channel between the hart (master) and memory (slave).
interface data_mem_if #(
  parameter int unsigned XLEN = isa_types::XLEN
);
  import isa_types::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [XLEN-1:0] req_addr;
  write_width_t    req_width;
  logic            req_unsigned;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_width, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_width, req_unsigned, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and sign/zero extension for loads on a 32-bit word.
module mem_lane_align
  import isa_types::*;
#(
  parameter int unsigned XLEN = isa_types::XLEN
) (
  input  logic [1:0]      byte_off,
  input  write_width_t    width,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata_word,
  output logic [3:0]      byte_mask,
  output logic [XLEN-1:0] wdata_shifted,
  output logic [XLEN-1:0] rdata_ext
);

  logic [XLEN-1:0] lane_sel;

  // Aligned accesses only: shifting by the byte offset puts the addressed lanes at bit 0.
  assign lane_sel = rdata_word >> {byte_off, 3'b000};

  always_comb begin
    byte_mask     = 4'b0000;
    wdata_shifted = '0;
    rdata_ext     = '0;
    case (width)
      WidthByte: begin
        byte_mask     = 4'b0001 << byte_off;
        wdata_shifted = {(XLEN / 8){wdata[7:0]}};
        rdata_ext     = {{(XLEN - 8){~is_unsigned & lane_sel[7]}}, lane_sel[7:0]};
      end
      WidthHalf: begin
        byte_mask     = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata_shifted = {(XLEN / 16){wdata[15:0]}};
        rdata_ext     = {{(XLEN - 16){~is_unsigned & lane_sel[15]}}, lane_sel[15:0]};
      end
      WidthWord: begin
        byte_mask     = 4'b1111;
        wdata_shifted = wdata;
        rdata_ext     = rdata_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering one load/store at a time after WAIT_CYCLES wait states.
module data_mem_responder
  import isa_types::*;
#(
  parameter int unsigned XLEN        = isa_types::XLEN,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic       clk,
  input logic       rst_n,
  data_mem_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  resp_state_t     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  mem_req_t        req_q, cur_req;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            error_q;
  logic            commit;
  logic            req_err;
  logic [IdxW-1:0] word_idx;
  logic [XLEN-1:0] rdata_word;
  logic [3:0]      byte_mask;
  logic [XLEN-1:0] wdata_shifted;
  logic [XLEN-1:0] rdata_ext;
  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // In IDLE the live bus request is used so a zero-wait access commits on its accept edge.
  always_comb begin
    cur_req = req_q;
    if (state_q == StIdle) begin
      cur_req.write       = bus.req_write;
      cur_req.addr        = bus.req_addr;
      cur_req.width       = bus.req_width;
      cur_req.is_unsigned = bus.req_unsigned;
      cur_req.wdata       = bus.req_wdata;
    end
  end

  assign req_err    = is_misaligned(cur_req.addr[1:0], cur_req.width) |
                      (|cur_req.addr[XLEN-1:IdxW+2]);
  assign word_idx   = cur_req.addr[IdxW+1:2];
  assign rdata_word = mem[word_idx];
  assign rdata_d    = (cur_req.write || req_err) ? '0 : rdata_ext;

  mem_lane_align #(
    .XLEN(XLEN)
  ) u_align (
    .byte_off     (cur_req.addr[1:0]),
    .width        (cur_req.width),
    .is_unsigned  (cur_req.is_unsigned),
    .wdata        (cur_req.wdata),
    .rdata_word   (rdata_word),
    .byte_mask    (byte_mask),
    .wdata_shifted(wdata_shifted),
    .rdata_ext    (rdata_ext)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && bus.req_valid) req_q <= cur_req;
      if (commit) begin
        rdata_q <= rdata_d;
        error_q <= req_err;
      end
    end
  end

  // RAM has no reset; a write is suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && commit && cur_req.write && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_mask[i]) mem[word_idx][8*i +: 8] <= wdata_shifted[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder at wait counts 1, 3 and 0 against a byte-array model.
module tb_data_mem_responder;
  import isa_types::*;

  localparam int unsigned Depth  = 256;
  localparam int          NumDut = 3;

  function automatic int unsigned wait_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n          [NumDut];
  logic         drv_valid      [NumDut];
  logic         drv_write      [NumDut];
  logic [31:0]  drv_addr       [NumDut];
  write_width_t drv_width      [NumDut];
  logic         drv_unsigned   [NumDut];
  logic [31:0]  drv_wdata      [NumDut];
  logic         drv_resp_ready [NumDut];
  logic         mon_req_ready  [NumDut];
  logic         mon_resp_valid [NumDut];
  logic [31:0]  mon_rdata      [NumDut];
  logic         mon_err        [NumDut];

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    data_mem_if #(.XLEN(32)) bus ();
    assign bus.req_valid     = drv_valid[g];
    assign bus.req_write     = drv_write[g];
    assign bus.req_addr      = drv_addr[g];
    assign bus.req_width     = drv_width[g];
    assign bus.req_unsigned  = drv_unsigned[g];
    assign bus.req_wdata     = drv_wdata[g];
    assign bus.resp_ready    = drv_resp_ready[g];
    assign mon_req_ready[g]  = bus.req_ready;
    assign mon_resp_valid[g] = bus.resp_valid;
    assign mon_rdata[g]      = bus.resp_rdata;
    assign mon_err[g]        = bus.resp_error;

    data_mem_responder #(
      .XLEN       (32),
      .DEPTH_WORDS(Depth),
      .WAIT_CYCLES(wait_of(g))
    ) dut (
      .clk  (clk),
      .rst_n(rst_n[g]),
      .bus  (bus)
    );
  end

  // Reference: byte-addressed memory, one outstanding request per DUT.
  logic [7:0]  mem_m   [NumDut][Depth*4];
  logic [31:0] exp_rdata [NumDut];
  logic        exp_err   [NumDut];
  int          acc_cnt   [NumDut];
  int          hs_cnt    [NumDut];
  int n_tests = 0, n_fail = 0;
  int m_tests = 0, m_fail = 0;

  function automatic void model_access(input int k, input logic wr, input logic [31:0] addr,
                                       input write_width_t w, input logic u,
                                       input logic [31:0] wd, output logic [31:0] rd,
                                       output logic er);
    int unsigned n;
    logic [31:0] v;
    n  = (w == WidthByte) ? 1 : ((w == WidthHalf) ? 2 : 4);
    v  = '0;
    rd = '0;
    er = ((addr % n) != 0) || (addr >= Depth * 4);
    if (er) return;
    for (int i = 0; i < int'(n); i++) begin
      if (wr) mem_m[k][addr + i] = wd[8*i +: 8];
      else    v[8*i +: 8] = mem_m[k][addr + i];
    end
    if (!wr) begin
      if (n < 4 && !u && v[8*n-1]) rd = v | (32'hFFFF_FFFF << (8 * n));
      else                          rd = v;
    end
  endfunction

  task automatic check(input int k, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d(wait=%0d) %s: got %h, expected %h", k, wait_of(k), name, act, exp);
    end
  endtask

  // Compare process: every falling edge, each DUT's outputs against the model.
  always @(negedge clk) begin
    for (int k = 0; k < NumDut; k++) begin
      if (rst_n[k] === 1'b1) begin
        if (acc_cnt[k] != hs_cnt[k]) begin
          m_tests++;
          if (mon_req_ready[k] !== 1'b0) begin
            m_fail++;
            $display("FAIL dut%0d busy_ready: got %b, expected 0", k, mon_req_ready[k]);
          end
          if (mon_resp_valid[k] === 1'b1) begin
            m_tests++;
            if (mon_rdata[k] !== exp_rdata[k] || mon_err[k] !== exp_err[k]) begin
              m_fail++;
              $display("FAIL dut%0d resp: got rdata=%h err=%b, expected rdata=%h err=%b", k,
                       mon_rdata[k], mon_err[k], exp_rdata[k], exp_err[k]);
            end
            if (drv_resp_ready[k]) hs_cnt[k]++;
          end
        end else begin
          m_tests++;
          if (mon_resp_valid[k] !== 1'b0) begin
            m_fail++;
            $display("FAIL dut%0d spurious_resp: got resp_valid=%b, expected 0", k,
                     mon_resp_valid[k]);
          end
        end
      end
    end
  end

  task automatic access(input int k, input logic wr, input logic [31:0] addr,
                        input write_width_t w, input logic u, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output logic er);
    logic [31:0] m_rd;
    logic        m_er;
    int          cyc;
    drv_valid[k]    = 1'b1;
    drv_write[k]    = wr;
    drv_addr[k]     = addr;
    drv_width[k]    = w;
    drv_unsigned[k] = u;
    drv_wdata[k]    = wd;
    cyc = 0;
    @(negedge clk);
    while (mon_req_ready[k] !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check(k, "accept_timeout", 32'(cyc), 32'(cyc < 20 ? cyc : 0));
    model_access(k, wr, addr, w, u, wd, m_rd, m_er);
    exp_rdata[k] = m_rd;
    exp_err[k]   = m_er;
    @(posedge clk);
    #1;
    acc_cnt[k]++;
    // Junk request while busy; it must be ignored.
    drv_write[k] = 1'($urandom);
    drv_addr[k]  = $urandom_range(0, 63);
    drv_wdata[k] = $urandom;
    cyc = 0;
    while (mon_resp_valid[k] !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(k, "latency", 32'(cyc), 32'(wait_of(k)));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
    end
    rd = mon_rdata[k];
    er = mon_err[k];
    drv_valid[k]      = 1'b0;
    drv_resp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    drv_resp_ready[k] = 1'b0;
    check(k, "ready_after_hs", {31'b0, mon_req_ready[k]}, 32'd1);
  endtask

  task automatic check_reset_vals(input int k);
    check(k, "rst_req_ready", {31'b0, mon_req_ready[k]}, 32'd1);
    check(k, "rst_resp_valid", {31'b0, mon_resp_valid[k]}, 32'd0);
    check(k, "rst_rdata", mon_rdata[k], 32'd0);
    check(k, "rst_error", {31'b0, mon_err[k]}, 32'd0);
  endtask

  task automatic reset_mid(input int k);
    logic [31:0] rd;
    logic        er;
    drv_valid[k]    = 1'b1;
    drv_write[k]    = 1'b1;
    drv_addr[k]     = 32'h20;
    drv_width[k]    = WidthWord;
    drv_unsigned[k] = 1'b0;
    drv_wdata[k]    = 32'hCAFE_F00D;
    @(negedge clk);
    @(posedge clk);
    #1;
    drv_valid[k] = 1'b0;
    rst_n[k]     = 1'b0;
    // Only a zero-wait DUT has passed its commit edge by now.
    if (wait_of(k) == 0) model_access(k, 1'b1, 32'h20, WidthWord, 1'b0, 32'hCAFE_F00D, rd, er);
    #2;
    check_reset_vals(k);
    repeat (2) @(posedge clk);
    #1;
    rst_n[k] = 1'b1;
    access(k, 1'b0, 32'h20, WidthWord, 1'b0, 32'h0, 0, rd, er);
    check(k, "rst_mid_reload", rd, (wait_of(k) == 0) ? 32'hCAFE_F00D : 32'h0);
  endtask

  task automatic run_dut(input int k);
    logic [31:0]  rd;
    logic         er;
    logic [31:0]  addr;
    write_width_t w;
    for (int a = 0; a < 64; a += 4) access(k, 1'b1, a, WidthWord, 1'b0, 32'h0, 0, rd, er);
    access(k, 1'b1, 32'h3FC, WidthWord, 1'b0, 32'h0, 0, rd, er);

    access(k, 1'b1, 32'h10, WidthWord, 1'b0, 32'hDEAD_BEEF, 0, rd, er);
    check(k, "st_word_rdata", rd, 32'h0);
    access(k, 1'b0, 32'h10, WidthWord, 1'b0, 32'h0, 0, rd, er);
    check(k, "ld_word", rd, 32'hDEAD_BEEF);
    check(k, "ld_word_err", {31'b0, er}, 32'd0);
    access(k, 1'b1, 32'h11, WidthByte, 1'b0, 32'h5555_5580, 0, rd, er);
    access(k, 1'b0, 32'h11, WidthByte, 1'b0, 32'h0, 0, rd, er);
    check(k, "lb", rd, 32'hFFFF_FF80);
    access(k, 1'b0, 32'h11, WidthByte, 1'b1, 32'h0, 0, rd, er);
    check(k, "lbu", rd, 32'h0000_0080);
    access(k, 1'b0, 32'h10, WidthWord, 1'b0, 32'h0, 0, rd, er);
    check(k, "ld_after_sb", rd, 32'hDEAD_80EF);
    access(k, 1'b1, 32'h12, WidthHalf, 1'b0, 32'hABCD_1234, 0, rd, er);
    access(k, 1'b0, 32'h10, WidthWord, 1'b0, 32'h0, 0, rd, er);
    check(k, "ld_after_sh", rd, 32'h1234_80EF);
    access(k, 1'b1, 32'h13, WidthHalf, 1'b0, 32'h0000_5678, 0, rd, er);
    check(k, "sh_misalign_err", {31'b0, er}, 32'd1);
    check(k, "sh_misalign_rdata", rd, 32'h0);
    access(k, 1'b0, 32'h10, WidthWord, 1'b0, 32'h0, 0, rd, er);
    check(k, "ld_after_bad_sh", rd, 32'h1234_80EF);
    access(k, 1'b0, 32'h12, WidthHalf, 1'b0, 32'h0, 0, rd, er);
    check(k, "lh_pos", rd, 32'h0000_1234);
    access(k, 1'b0, 32'h400, WidthWord, 1'b0, 32'h0, 0, rd, er);
    check(k, "oor_err", {31'b0, er}, 32'd1);
    check(k, "oor_rdata", rd, 32'h0);
    access(k, 1'b1, 32'h3FC, WidthWord, 1'b0, 32'h0BAD_C0DE, 0, rd, er);
    access(k, 1'b0, 32'h3FC, WidthWord, 1'b0, 32'h0, 0, rd, er);
    check(k, "top_word", rd, 32'h0BAD_C0DE);
    check(k, "top_word_err", {31'b0, er}, 32'd0);
    access(k, 1'b0, 32'h3FE, WidthHalf, 1'b0, 32'h0, 5, rd, er);
    check(k, "held_lh", rd, 32'h0000_0BAD);

    reset_mid(k);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       addr = 32'h3FC + $urandom_range(0, 3);
        1:       addr = 32'h400 + $urandom_range(0, 15);
        2:       addr = $urandom | 32'h8000_0000;
        default: addr = $urandom_range(0, 63);
      endcase
      w = write_width_t'($urandom_range(0, 2));
      access(k, 1'($urandom), addr, w, 1'($urandom), $urandom, int'($urandom_range(0, 3)),
             rd, er);
    end
  endtask

  initial begin
    for (int k = 0; k < NumDut; k++) begin
      rst_n[k]          = 1'b0;
      drv_valid[k]      = 1'b0;
      drv_write[k]      = 1'b0;
      drv_addr[k]       = '0;
      drv_width[k]      = WidthWord;
      drv_unsigned[k]   = 1'b0;
      drv_wdata[k]      = '0;
      drv_resp_ready[k] = 1'b0;
      acc_cnt[k]        = 0;
      exp_rdata[k]      = '0;
      exp_err[k]        = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NumDut; k++) check_reset_vals(k);
    for (int k = 0; k < NumDut; k++) rst_n[k] = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < NumDut; k++) run_dut(k);
    repeat (3) @(posedge clk);
    n_tests += m_tests;
    n_fail  += m_fail;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    for (int k = 0; k < NumDut; k++) hs_cnt[k] = 0;
  end

endmodule
